// File: rtl/stage_3_collector_pkg.sv
// Shared constants and types for the stage_3 collector: fixed-point input
// format, IEEE-754 single layout and the pair entry held in the FIFO.
package stage_3_collector_pkg;

    localparam int CORDIC_DATA_WIDTH = 22;
    localparam int CORDIC_FRAC_BITS  = 20;
    localparam int FLOAT_DATA_WIDTH  = 32;
    localparam int FLOAT_MANT_W      = 23;
    localparam int FLOAT_BIAS        = 127;
    localparam logic [FLOAT_DATA_WIDTH-1:0] FLOAT_ZERO = '0;

    // Pair entries buffered; must be a power of two so the pointers wrap naturally.
    localparam int FIFO_DEPTH = 4;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);

    // One buffered pair: x_one (a) then x_two (b), 128 bits total.
    typedef struct packed {
        logic [FLOAT_DATA_WIDTH-1:0] a_conv;
        logic [FLOAT_DATA_WIDTH-1:0] a_sq;
        logic [FLOAT_DATA_WIDTH-1:0] b_conv;
        logic [FLOAT_DATA_WIDTH-1:0] b_sq;
    } pair_t;

endpackage

// File: rtl/stage_3_collector_fixed_to_float.sv
// Combinational signed Q1.20 to IEEE-754 single conversion. The 22-bit
// magnitude fits inside the 24-bit significand, so the result is exact.
module stage_3_collector_fixed_to_float
    import stage_3_collector_pkg::*;
(
    input  logic [CORDIC_DATA_WIDTH-1:0] fixed_in,
    output logic [FLOAT_DATA_WIDTH-1:0]  float_out
);

    localparam int LEAD_W = $clog2(CORDIC_DATA_WIDTH);
    localparam int NORM_W = FLOAT_MANT_W + 1;

    logic                         sign;
    logic [CORDIC_DATA_WIDTH-1:0] mag;
    logic [LEAD_W-1:0]            lead;
    logic [LEAD_W-1:0]            shamt;
    logic [NORM_W-1:0]            norm;
    logic [7:0]                   exp_val;

    // Magnitude, leading-one detect and normalisation; -2^21 negates to
    // 0x200000, which is correct when read as unsigned.
    always_comb begin
        sign  = fixed_in[CORDIC_DATA_WIDTH-1];
        mag   = sign ? (~fixed_in + CORDIC_DATA_WIDTH'(1)) : fixed_in;
        lead  = '0;
        for (int i = 0; i < CORDIC_DATA_WIDTH; i++) begin
            if (mag[i]) begin
                lead = LEAD_W'(i);
            end
        end
        shamt   = LEAD_W'(FLOAT_MANT_W) - lead;
        norm    = NORM_W'(mag) << shamt;
        exp_val = 8'(FLOAT_BIAS + int'(lead) - CORDIC_FRAC_BITS);
        if (mag == '0) begin
            float_out = FLOAT_ZERO;
        end else begin
            float_out = {sign, exp_val, norm[FLOAT_MANT_W-1:0]};
        end
    end

endmodule

// File: rtl/stage_3_collector.sv
// Collects stage_2's interleaved samples, converts the fixed-point result to
// float, pairs x_one/x_two and buffers pairs for the float summation stage.
// stage_2 cannot be stalled, so a full FIFO drops pairs and flags overflow.
module stage_3_collector
    import stage_3_collector_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clk_en,
    input  logic [CORDIC_DATA_WIDTH-1:0] result_in,
    input  logic [FLOAT_DATA_WIDTH-1:0]  squared_in,
    input  logic                         valid_in,
    input  logic                         pipeline_cleared_in,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [FLOAT_DATA_WIDTH-1:0]  out_a_conv,
    output logic [FLOAT_DATA_WIDTH-1:0]  out_a_sq,
    output logic [FLOAT_DATA_WIDTH-1:0]  out_b_conv,
    output logic [FLOAT_DATA_WIDTH-1:0]  out_b_sq,
    output logic                         done,
    output logic                         overflow
);

    logic [FLOAT_DATA_WIDTH-1:0] conv_float;

    logic                        conv_valid_q, conv_valid_d;
    logic [FLOAT_DATA_WIDTH-1:0] conv_data_q,  conv_data_d;
    logic [FLOAT_DATA_WIDTH-1:0] conv_sq_q,    conv_sq_d;
    logic                        half_valid_q, half_valid_d;
    logic [FLOAT_DATA_WIDTH-1:0] half_conv_q,  half_conv_d;
    logic [FLOAT_DATA_WIDTH-1:0] half_sq_q,    half_sq_d;
    logic                        seen_q,       seen_d;
    logic [PTR_W-1:0]            wr_ptr_q,     wr_ptr_d;
    logic [PTR_W-1:0]            rd_ptr_q,     rd_ptr_d;
    logic [PTR_W:0]              count_q,      count_d;
    pair_t                       last_q,       last_d;
    logic                        overflow_q,   overflow_d;
    logic                        done_q,       done_d;

    pair_t fifo_mem_q [FIFO_DEPTH];
    pair_t head;
    pair_t out_pair;
    pair_t push_data;
    logic  push_req;
    logic  push_ok;
    logic  pop;

    stage_3_collector_fixed_to_float u_f2f (
        .fixed_in  (result_in),
        .float_out (conv_float)
    );

    // Conversion stage, pairing, deferred end-of-batch flush and FIFO bookkeeping.
    always_comb begin
        conv_valid_d = conv_valid_q;
        conv_data_d  = conv_data_q;
        conv_sq_d    = conv_sq_q;
        half_valid_d = half_valid_q;
        half_conv_d  = half_conv_q;
        half_sq_d    = half_sq_q;
        seen_d       = seen_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        last_d       = last_q;
        overflow_d   = overflow_q;
        done_d       = done_q;
        push_req     = 1'b0;
        push_data    = '0;

        head = fifo_mem_q[rd_ptr_q];
        pop  = clk_en && (count_q != '0) && out_ready;

        if (clk_en) begin
            conv_valid_d = valid_in;
            conv_data_d  = conv_float;
            conv_sq_d    = squared_in;
            if (conv_valid_q) begin
                if (half_valid_q) begin
                    push_req     = 1'b1;
                    push_data    = '{a_conv: half_conv_q, a_sq: half_sq_q,
                                     b_conv: conv_data_q, b_sq: conv_sq_q};
                    half_valid_d = 1'b0;
                end else begin
                    half_valid_d = 1'b1;
                    half_conv_d  = conv_data_q;
                    half_sq_d    = conv_sq_q;
                end
            end else if ((seen_q || pipeline_cleared_in) && half_valid_q && !valid_in) begin
                // Flush only once nothing else is heading for the half slot.
                push_req     = 1'b1;
                push_data    = '{a_conv: half_conv_q, a_sq: half_sq_q,
                                 b_conv: FLOAT_ZERO, b_sq: FLOAT_ZERO};
                half_valid_d = 1'b0;
            end
            if (pipeline_cleared_in) begin
                seen_d = 1'b1;
            end else if (valid_in) begin
                seen_d = 1'b0;
            end
        end

        // A full FIFO still accepts a push when the head leaves on the same edge.
        push_ok = push_req && ((count_q != (PTR_W+1)'(FIFO_DEPTH)) || pop);
        if (push_req && !push_ok) begin
            overflow_d = 1'b1;
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            last_d   = head;
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase

        if (clk_en) begin
            done_d = seen_d && !conv_valid_d && !half_valid_d && (count_d == '0);
        end
    end

    // State registers; clk_en low is handled by the hold defaults above.
    always_ff @(posedge clk) begin
        if (rst) begin
            conv_valid_q <= 1'b0;
            conv_data_q  <= '0;
            conv_sq_q    <= '0;
            half_valid_q <= 1'b0;
            half_conv_q  <= '0;
            half_sq_q    <= '0;
            seen_q       <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            last_q       <= '0;
            overflow_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            conv_valid_q <= conv_valid_d;
            conv_data_q  <= conv_data_d;
            conv_sq_q    <= conv_sq_d;
            half_valid_q <= half_valid_d;
            half_conv_q  <= half_conv_d;
            half_sq_q    <= half_sq_d;
            seen_q       <= seen_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            last_q       <= last_d;
            overflow_q   <= overflow_d;
            done_q       <= done_d;
        end
    end

    // Pair storage; contents need no reset because the count gates visibility.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            fifo_mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Outputs present the FIFO head, or the last popped pair while empty.
    always_comb begin
        out_valid  = (count_q != '0);
        out_pair   = out_valid ? head : last_q;
        out_a_conv = out_pair.a_conv;
        out_a_sq   = out_pair.a_sq;
        out_b_conv = out_pair.b_conv;
        out_b_sq   = out_pair.b_sq;
        done       = done_q;
        overflow   = overflow_q;
    end

endmodule

// File: tb/tb_stage_3_collector.sv
// Directed bench for stage_3_collector: conversion values, pairing latency,
// overflow, end-of-batch flush, full+pop+push, reset and clk_en freeze.
module tb_stage_3_collector;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_en = 1'b1;
    logic [21:0] result_in = '0;
    logic [31:0] squared_in = '0;
    logic        valid_in = 1'b0;
    logic        pipeline_cleared_in = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_a_conv, out_a_sq, out_b_conv, out_b_sq;
    logic        done, overflow;

    int n_checks = 0;
    int n_fail   = 0;

    stage_3_collector dut (
        .clk                 (clk),
        .rst                 (rst),
        .clk_en              (clk_en),
        .result_in           (result_in),
        .squared_in          (squared_in),
        .valid_in            (valid_in),
        .pipeline_cleared_in (pipeline_cleared_in),
        .out_ready           (out_ready),
        .out_valid           (out_valid),
        .out_a_conv          (out_a_conv),
        .out_a_sq            (out_a_sq),
        .out_b_conv          (out_b_conv),
        .out_b_sq            (out_b_sq),
        .done                (done),
        .overflow            (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [21:0] x, input logic [31:0] sq);
        valid_in   = 1'b1;
        result_in  = x;
        squared_in = sq;
        @(negedge clk);
        valid_in   = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int i = 0;
        while (!out_valid && i < 20) begin
            @(negedge clk);
            i++;
        end
        check(tag, 32'(out_valid), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset state and basic pair latency
        @(negedge clk);
        do_reset();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_ovf",   32'(overflow), 32'd0);
        check("rst_a_conv", out_a_conv, 32'h0);
        send(22'h100000, 32'h3F800000);
        send(22'h080000, 32'h3E800000);
        check("t1_lat_early", 32'(out_valid), 32'd0);
        idle(1);
        check("t1_lat_valid", 32'(out_valid), 32'd1);
        check("t1_a_conv", out_a_conv, 32'h3F800000);
        check("t1_a_sq",   out_a_sq,   32'h3F800000);
        check("t1_b_conv", out_b_conv, 32'h3F000000);
        check("t1_b_sq",   out_b_sq,   32'h3E800000);
        pop_one();
        check("t1_empty", 32'(out_valid), 32'd0);
        check("t1_hold_a", out_a_conv, 32'h3F800000);
        check("t1_hold_bsq", out_b_sq, 32'h3E800000);

        // 2: conversion corner values
        send(22'h300000, 32'h1);
        send(22'h200000, 32'h2);
        wait_valid("t2_valid1");
        check("t2_neg_one", out_a_conv, 32'hBF800000);
        check("t2_neg_two", out_b_conv, 32'hC0000000);
        pop_one();
        send(22'h000000, 32'h3);
        send(22'h100000, 32'h4);
        wait_valid("t2_valid2");
        check("t2_zero", out_a_conv, 32'h00000000);
        check("t2_one",  out_b_conv, 32'h3F800000);
        pop_one();

        // 3: overflow with no readiness
        for (int k = 0; k < 4; k++) begin
            send(22'h100000, 32'hA0000000 | k);
            send(22'h080000, 32'hB0000000 | k);
        end
        idle(2);
        check("t3_no_ovf", 32'(overflow), 32'd0);
        send(22'h100000, 32'hA0000004);
        send(22'h080000, 32'hB0000004);
        idle(2);
        check("t3_ovf", 32'(overflow), 32'd1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t3_a_sq%0d", k), out_a_sq, 32'hA0000000 | k);
            check($sformatf("t3_b_sq%0d", k), out_b_sq, 32'hB0000000 | k);
            pop_one();
        end
        check("t3_drained", 32'(out_valid), 32'd0);
        check("t3_ovf_sticky", 32'(overflow), 32'd1);

        // 6a: reset with buffered pairs
        send(22'h100000, 32'h61);
        send(22'h080000, 32'h62);
        send(22'h100000, 32'h63);
        send(22'h080000, 32'h64);
        idle(2);
        check("t6_pre_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_done",  32'(done), 32'd0);
        check("t6_rst_ovf",   32'(overflow), 32'd0);
        idle(3);
        check("t6_rst_stays", 32'(out_valid), 32'd0);

        // 4: odd sample count, flush and done
        send(22'h100000, 32'h11);
        send(22'h080000, 32'h22);
        send(22'h040000, 32'h33);
        pipeline_cleared_in = 1'b1;
        @(negedge clk);
        pipeline_cleared_in = 1'b0;
        wait_valid("t4_valid1");
        check("t4_p1_a", out_a_conv, 32'h3F800000);
        check("t4_p1_bsq", out_b_sq, 32'h22);
        pop_one();
        wait_valid("t4_valid2");
        check("t4_done_busy", 32'(done), 32'd0);
        check("t4_p2_a",   out_a_conv, 32'h3E800000);
        check("t4_p2_asq", out_a_sq,   32'h33);
        check("t4_p2_b",   out_b_conv, 32'h0);
        check("t4_p2_bsq", out_b_sq,   32'h0);
        pop_one();
        check("t4_done", 32'(done), 32'd1);
        send(22'h100000, 32'h44);
        check("t4_done_clr", 32'(done), 32'd0);
        do_reset();

        // 5: full FIFO with simultaneous pop and push
        for (int k = 0; k < 5; k++) begin
            send(22'h100000, 32'hC0000000 | k);
            send(22'h080000, 32'hD0000000 | k);
            if (k == 4) begin
                out_ready = 1'b1;
                @(negedge clk);
                out_ready = 1'b0;
            end
        end
        check("t5_no_ovf", 32'(overflow), 32'd0);
        for (int k = 1; k < 5; k++) begin
            check($sformatf("t5_a_sq%0d", k), out_a_sq, 32'hC0000000 | k);
            check($sformatf("t5_b_sq%0d", k), out_b_sq, 32'hD0000000 | k);
            pop_one();
        end
        check("t5_drained", 32'(out_valid), 32'd0);

        // 6b: clk_en low freezes state and ignores samples
        send(22'h100000, 32'hE1);
        clk_en     = 1'b0;
        valid_in   = 1'b1;
        result_in  = 22'h200000;
        squared_in = 32'hEE;
        out_ready  = 1'b1;
        idle(3);
        valid_in   = 1'b0;
        out_ready  = 1'b0;
        clk_en     = 1'b1;
        check("t6_en_novalid", 32'(out_valid), 32'd0);
        send(22'h080000, 32'hE2);
        wait_valid("t6_en_valid");
        check("t6_en_asq", out_a_sq, 32'hE1);
        check("t6_en_bsq", out_b_sq, 32'hE2);
        check("t6_en_b",   out_b_conv, 32'h3F000000);
        clk_en    = 1'b0;
        out_ready = 1'b1;
        idle(2);
        check("t6_en_hold", 32'(out_valid), 32'd1);
        check("t6_en_hold_a", out_a_sq, 32'hE1);
        clk_en = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("t6_en_pop", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
